// File: rtl/clock_enable_gen.sv
// Free-running counter with per-tap rising/falling clock-enable strobes, run/hold,
// frame-sync realignment with alignment-error reporting, and a wrap-aligned tap select.
module clock_enable_gen #(
    parameter int               CNT_W    = 10,
    parameter logic [CNT_W-1:0] SYNC_VAL = '0,
    parameter int               SEL_W    = $clog2(CNT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sync,
    input  logic [SEL_W-1:0] rate_sel,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] pos_en,
    output logic [CNT_W-1:0] neg_en,
    output logic             sel_pos_en,
    output logic             sel_neg_en,
    output logic             locked,
    output logic             sync_err
);

    logic             run_q;
    logic [SEL_W-1:0] rate_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_expected;
    logic             frame_wrap;

    assign cnt_inc      = cnt + CNT_W'(1);
    assign cnt_expected = run_q ? cnt_inc : cnt;
    assign frame_wrap   = run_q & (&cnt);

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            run_q    <= 1'b0;
            rate_q   <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            run_q <= run;
            if (sync) begin
                cnt      <= SYNC_VAL;
                locked   <= 1'b1;
                sync_err <= locked & (cnt_expected != SYNC_VAL);
            end else begin
                sync_err <= 1'b0;
                if (run_q) begin
                    cnt <= cnt_inc;
                end
            end
            // Tap changes only at frame boundaries so the selected strobe never runts.
            if (sync || frame_wrap) begin
                rate_q <= rate_sel;
            end
        end
    end

    // Tap k fires pos when bits below k are all ones and bit k is 0; neg when bits 0..k are all ones.
    always_comb begin
        logic ones;
        ones   = 1'b1;
        pos_en = '0;
        neg_en = '0;
        for (int k = 0; k < CNT_W; k++) begin
            pos_en[k] = run_q & ones & ~cnt[k];
            ones      = ones & cnt[k];
            neg_en[k] = run_q & ones;
        end
    end

    always_comb begin
        sel_pos_en = 1'b0;
        sel_neg_en = 1'b0;
        if (int'(rate_q) < CNT_W) begin
            sel_pos_en = pos_en[rate_q];
            sel_neg_en = neg_en[rate_q];
        end
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised and directed bench for clock_enable_gen against an arithmetic reference model.
module tb_clock_enable_gen;

    localparam int CNT_W  = 10;
    localparam int SEL_W  = 4;
    localparam int MOD    = 1 << CNT_W;
    localparam int SYNC_V = 0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             sync = 1'b0;
    logic [SEL_W-1:0] rate_sel = '0;
    logic [CNT_W-1:0] cnt, pos_en, neg_en;
    logic             sel_pos_en, sel_neg_en, locked, sync_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cnt    = 0;
    bit m_run_q  = 0;
    int m_rate   = 0;
    bit m_locked = 0;
    bit m_err    = 0;

    always #5 clk = ~clk;

    clock_enable_gen #(
        .CNT_W   (CNT_W),
        .SYNC_VAL(CNT_W'(SYNC_V)),
        .SEL_W   (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .sync      (sync),
        .rate_sel  (rate_sel),
        .cnt       (cnt),
        .pos_en    (pos_en),
        .neg_en    (neg_en),
        .sel_pos_en(sel_pos_en),
        .sel_neg_en(sel_neg_en),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    function automatic logic [CNT_W-1:0] exp_pos();
        logic [CNT_W-1:0] r = '0;
        for (int k = 0; k < CNT_W; k++)
            if (m_run_q && (m_cnt % (1 << (k + 1))) == (1 << k) - 1) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] exp_neg();
        logic [CNT_W-1:0] r = '0;
        for (int k = 0; k < CNT_W; k++)
            if (m_run_q && (m_cnt % (1 << (k + 1))) == (1 << (k + 1)) - 1) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_sel(input bit neg);
        logic [CNT_W-1:0] v;
        v = neg ? exp_neg() : exp_pos();
        if (m_rate < CNT_W) return v[m_rate];
        return 1'b0;
    endfunction

    // Apply inputs, advance one edge, update the model, land on the sampling edge.
    task automatic step(input bit r_i, input bit run_i, input bit sync_i);
        int  nxt;
        bit  wrap;
        rst  = r_i;
        run  = run_i;
        sync = sync_i;
        @(posedge clk);
        if (r_i) begin
            m_cnt = 0; m_run_q = 0; m_rate = 0; m_locked = 0; m_err = 0;
        end else begin
            nxt  = m_run_q ? (m_cnt + 1) % MOD : m_cnt;
            wrap = m_run_q && (m_cnt == MOD - 1);
            if (sync_i) begin
                m_err    = m_locked && (nxt != SYNC_V);
                m_locked = 1;
                m_cnt    = SYNC_V;
            end else begin
                m_err = 0;
                if (m_run_q) m_cnt = (m_cnt + 1) % MOD;
            end
            if (sync_i || wrap) m_rate = int'(rate_sel);
            m_run_q = run_i;
        end
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        bool_loop: for (int i = 0; i < 2100; i++) begin
            if (m_cnt == target) break;
            step(0, 1, 0);
        end
        total++;
        if (m_cnt != target) begin
            bad++;
            $display("FAIL run_to: model cnt=%0d never reached %0d", m_cnt, target);
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        total++;
        if (cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        total++;
        if ((pos_en | neg_en) !== '0) begin
            bad++; $display("FAIL reset_strobes: pos=%h neg=%h want 0", pos_en, neg_en);
        end
        total++;
        if ({locked, sync_err, sel_pos_en, sel_neg_en} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {locked, sync_err, sel_pos_en, sel_neg_en});
        end
    endtask

    task automatic test_counting();
        step(0, 1, 0);
        for (int i = 0; i < 1100; i++) begin
            total++;
            if (cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL count_cnt: got %0d want %0d", cnt, m_cnt); end
            total++;
            if (pos_en !== exp_pos()) begin bad++; $display("FAIL count_pos: cnt=%0d got %h want %h", m_cnt, pos_en, exp_pos()); end
            total++;
            if (neg_en !== exp_neg()) begin bad++; $display("FAIL count_neg: cnt=%0d got %h want %h", m_cnt, neg_en, exp_neg()); end
            if (m_cnt == 511) begin
                total++;
                if (pos_en[9] !== 1'b1) begin bad++; $display("FAIL pos9_at_511: got %b want 1", pos_en[9]); end
            end
            if (m_cnt == 1023) begin
                total++;
                if (neg_en[9] !== 1'b1) begin bad++; $display("FAIL neg9_at_1023: got %b want 1", neg_en[9]); end
            end
            step(0, 1, 0);
        end
    endtask

    task automatic test_run_hold();
        run_to(200);
        step(0, 0, 0);
        total++;
        if (cnt !== 10'd201) begin bad++; $display("FAIL hold_first: got %0d want 201", cnt); end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            total++;
            if (cnt !== 10'd201 || pos_en !== '0 || neg_en !== '0) begin
                bad++; $display("FAIL hold: cnt=%0d pos=%h neg=%h want 201/0/0", cnt, pos_en, neg_en);
            end
        end
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 0);
            total++;
            if (cnt !== CNT_W'(m_cnt) || pos_en !== exp_pos() || neg_en !== exp_neg()) begin
                bad++; $display("FAIL resume: cnt=%0d pos=%h neg=%h want %0d/%h/%h",
                                cnt, pos_en, neg_en, m_cnt, exp_pos(), exp_neg());
            end
        end
    endtask

    task automatic test_sync();
        step(1, 0, 0);
        step(0, 1, 0);
        run_to(37);
        step(0, 1, 1);
        total++;
        if ({cnt, locked, sync_err} !== {10'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL first_sync: cnt=%0d locked=%b err=%b want 0/1/0", cnt, locked, sync_err);
        end
        run_to(500);
        step(0, 1, 1);
        total++;
        if (sync_err !== 1'b1 || cnt !== '0) begin
            bad++; $display("FAIL misaligned_sync: err=%b cnt=%0d want 1/0", sync_err, cnt);
        end
        step(0, 1, 0);
        total++;
        if (sync_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %b want 0", sync_err); end
        run_to(1023);
        step(0, 1, 1);
        total++;
        if (sync_err !== 1'b0 || cnt !== '0) begin
            bad++; $display("FAIL aligned_sync: err=%b cnt=%0d want 0/0", sync_err, cnt);
        end
    endtask

    task automatic test_rate_sel();
        int n_pos, n_neg;
        rate_sel = 4'd3;
        run_to(1023);
        step(0, 1, 0);
        run_to(300);
        rate_sel = 4'd5;
        n_pos = 0;
        for (int i = 0; i < 724; i++) begin
            n_pos += int'(sel_pos_en);
            total++;
            if (sel_pos_en !== exp_sel(0)) begin bad++; $display("FAIL sel_tap3: cnt=%0d got %b want %b", m_cnt, sel_pos_en, exp_sel(0)); end
            step(0, 1, 0);
        end
        total++;
        if (n_pos != 45) begin bad++; $display("FAIL tap3_count: got %0d want 45", n_pos); end
        n_pos = 0; n_neg = 0;
        for (int i = 0; i < 1024; i++) begin
            n_pos += int'(sel_pos_en);
            n_neg += int'(sel_neg_en);
            step(0, 1, 0);
        end
        total++;
        if (n_pos != 16 || n_neg != 16) begin bad++; $display("FAIL tap5_count: pos=%0d neg=%0d want 16/16", n_pos, n_neg); end
        rate_sel = 4'd12;
        run_to(1023);
        step(0, 1, 0);
        n_pos = 0;
        for (int i = 0; i < 1024; i++) begin
            n_pos += int'(sel_pos_en) + int'(sel_neg_en);
            step(0, 1, 0);
        end
        total++;
        if (n_pos != 0) begin bad++; $display("FAIL rate_out_of_range: got %0d strobes want 0", n_pos); end
        rate_sel = '0;
    endtask

    task automatic test_reset_sync();
        run_to(700);
        step(1, 1, 1);
        total++;
        if ({cnt, locked, sync_err, sel_pos_en, sel_neg_en} !== '0 || (pos_en | neg_en) !== '0) begin
            bad++; $display("FAIL reset_with_sync: cnt=%0d locked=%b err=%b pos=%h neg=%h want all 0",
                            cnt, locked, sync_err, pos_en, neg_en);
        end
    endtask

    task automatic test_random();
        bit r_i, run_i, s_i;
        run_i = 1;
        for (int i = 0; i < 3000; i++) begin
            r_i = ($urandom_range(0, 499) == 0);
            s_i = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) run_i = ~run_i;
            if ($urandom_range(0, 99) == 0) rate_sel = SEL_W'($urandom_range(0, 15));
            step(r_i, run_i, s_i);
            total++;
            if (cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd_cnt: got %0d want %0d", cnt, m_cnt); end
            total++;
            if (pos_en !== exp_pos() || neg_en !== exp_neg()) begin
                bad++; $display("FAIL rnd_strobes: pos=%h neg=%h want %h/%h", pos_en, neg_en, exp_pos(), exp_neg());
            end
            total++;
            if (sel_pos_en !== exp_sel(0) || sel_neg_en !== exp_sel(1)) begin
                bad++; $display("FAIL rnd_sel: got %b%b want %b%b", sel_pos_en, sel_neg_en, exp_sel(0), exp_sel(1));
            end
            total++;
            if (locked !== m_locked || sync_err !== m_err) begin
                bad++; $display("FAIL rnd_flags: locked=%b err=%b want %b/%b", locked, sync_err, m_locked, m_err);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_counting();
        test_run_hold();
        test_sync();
        test_rate_sel();
        test_reset_sync();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
